// File: rtl/irq_flag_scheduler.sv
// ============================================================================
// irq_flag_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//   This module collects single-cycle event pulses from N_SRC peripherals
//   into sticky per-source pending flags. It presents one pending, enabled
//   source at a time on the processor interrupt pins and picks that source
//   round-robin. It clears the served flag when the processor acknowledges.
//
// Ports:
//   C            in   1      clock, rising edge
//   R            in   1      synchronous active-high reset
//   src_pulse    in   N_SRC  per-source event pulse (one cycle per event)
//   src_en       in   N_SRC  per-source enable (gates flag set and selection)
//   clr_all      in   1      synchronous clear of all pending flags
//   irq_ack      in   1      single-cycle acknowledge from processor
//   irq          out  1      interrupt request
//   irq_vec      out  VEC_W  index of presented source, valid while irq=1
//   pending      out  N_SRC  current pending flags
//   timeout_err  out  1      sticky: a presentation timed out
//
// Parameters:
//   N_SRC    number of event sources (2..8)
//   VEC_W    width of irq_vec, 2**VEC_W >= N_SRC
//   TIMEOUT  ASSERT cycles before an unacknowledged presentation is dropped
//            (1..65535, only meaningful with IRQ_TIMEOUT_EN)
//
// Build option:
//   IRQ_TIMEOUT_EN  when defined, a presentation that gets no acknowledge
//                   for TIMEOUT cycles is dropped. The flag stays pending,
//                   the next source gets priority, and timeout_err is set
//                   until R. When undefined, ASSERT waits indefinitely and
//                   timeout_err is tied 0.
// ============================================================================
module irq_flag_scheduler #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned VEC_W   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             C,
    input  logic             R,
    input  logic [N_SRC-1:0] src_pulse,
    input  logic [N_SRC-1:0] src_en,
    input  logic             clr_all,
    input  logic             irq_ack,
    output logic             irq,
    output logic [VEC_W-1:0] irq_vec,
    output logic [N_SRC-1:0] pending,
    output logic             timeout_err
);

    // Index width needed to address a source bit; never wider than VEC_W.
    localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (N_SRC < 2 || N_SRC > 8) begin : g_bad_n_src
        $error("irq_flag_scheduler: N_SRC must be in 2..8");
    end
    if ((1 << VEC_W) < N_SRC) begin : g_bad_vec_w
        $error("irq_flag_scheduler: VEC_W too narrow for N_SRC");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("irq_flag_scheduler: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [VEC_W-1:0]   last_q,    last_d;
    logic [VEC_W-1:0]   vec_q,     vec_d;
    logic               irq_q,     irq_d;

`ifdef IRQ_TIMEOUT_EN
    logic [15:0]        cnt_q,     cnt_d;
    logic               terr_q,    terr_d;
    logic               timeout_hit;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N_SRC-1:0]   req;
    logic               req_any;
    logic [VEC_W-1:0]   sel_idx;
    logic               sel_found;
    logic               vec_enabled;
    logic [N_SRC-1:0]   clear_srv;

    assign req         = pending_q & src_en;
    assign req_any     = |req;
    assign vec_enabled = src_en[vec_q[IW-1:0]];

`ifdef IRQ_TIMEOUT_EN
    // cnt_q counts ASSERT cycles already spent without an acknowledge. The
    // TIMEOUT-th such cycle is therefore the one where cnt_q == TIMEOUT-1.
    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
`endif

    // Round-robin pick. Scan last+1, last+2, ... with wrap. The scan covers
    // N_SRC positions, so last itself is checked at the end of the scan.
    always_comb begin
        int unsigned idx;
        sel_idx   = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!sel_found && req[idx[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = VEC_W'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        last_d    = last_q;
        irq_d     = irq_q;
        clear_srv = '0;
`ifdef IRQ_TIMEOUT_EN
        terr_d    = terr_q;
        // The counter is zero everywhere except ASSERT, so every entry to
        // ASSERT starts from zero.
        cnt_d     = (state_q == ST_ASSERT) ? cnt_q + 16'd1 : '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (req_any) begin
                    state_d = ST_ASSERT;
                    irq_d   = 1'b1;
                    vec_d   = sel_idx;
                end
            end

            ST_ASSERT: begin
                irq_d = 1'b1;
                if (irq_ack) begin
                    // Acknowledge wins over abort and timeout in the same cycle.
                    for (int unsigned i = 0; i < N_SRC; i++) begin
                        clear_srv[i] = (vec_q == VEC_W'(i));
                    end
                    last_d  = vec_q;
                    irq_d   = 1'b0;
                    state_d = ST_GAP;
                end else if (!vec_enabled || clr_all) begin
                    // Withdrawn presentation: the scan pointer does not
                    // advance, so this source keeps its place in line.
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef IRQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    // The flag stays pending. The pointer advances so the
                    // unresponsive source does not block the others.
                    last_d  = vec_q;
                    irq_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = ST_GAP;
                end
`endif
            end

            ST_GAP: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending flags: clr_all > new event > service clear > hold
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (clr_all) begin
                pending_d[i] = 1'b0;
            end else if (src_pulse[i] && src_en[i]) begin
                pending_d[i] = 1'b1;
            end else if (clear_srv[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge C) begin
        if (R) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            last_q    <= VEC_W'(N_SRC - 1);
            vec_q     <= '0;
            irq_q     <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
            cnt_q     <= '0;
            terr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            vec_q     <= vec_d;
            irq_q     <= irq_d;
`ifdef IRQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
`endif
        end
    end

    assign irq     = irq_q;
    assign irq_vec = vec_q;
    assign pending = pending_q;

`ifdef IRQ_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_irq_flag_scheduler.sv
// ============================================================================
// tb_irq_flag_scheduler
// ----------------------------------------------------------------------------
// Directed bench for irq_flag_scheduler with N_SRC=4, VEC_W=2, TIMEOUT=8.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at
// that same point, so they show the state after that edge.
// ============================================================================
module tb_irq_flag_scheduler;

    localparam int unsigned N_SRC   = 4;
    localparam int unsigned VEC_W   = 2;
    localparam int unsigned TIMEOUT = 8;

    logic             C = 1'b0;
    logic             R;
    logic [N_SRC-1:0] src_pulse;
    logic [N_SRC-1:0] src_en;
    logic             clr_all;
    logic             irq_ack;
    logic             irq;
    logic [VEC_W-1:0] irq_vec;
    logic [N_SRC-1:0] pending;
    logic             timeout_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    irq_flag_scheduler #(
        .N_SRC   (N_SRC),
        .VEC_W   (VEC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .C           (C),
        .R           (R),
        .src_pulse   (src_pulse),
        .src_en      (src_en),
        .clr_all     (clr_all),
        .irq_ack     (irq_ack),
        .irq         (irq),
        .irq_vec     (irq_vec),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    task automatic do_reset;
        R         = 1'b1;
        src_pulse = '0;
        src_en    = 4'hF;
        clr_all   = 1'b0;
        irq_ack   = 1'b0;
        tick;
        tick;
        R = 1'b0;
    endtask

    // Expects a presentation of source v. Acknowledges it and checks the
    // low cycles that follow. Returns after the edge where the next
    // presentation (if any) begins.
    task automatic serve(input logic [1:0] v, input string tag);
        check({tag, "_irq"}, 32'(irq), 32'd1);
        check({tag, "_vec"}, 32'(irq_vec), 32'(v));
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        check({tag, "_gap"}, 32'(irq), 32'd0);
        tick;
        check({tag, "_idle"}, 32'(irq), 32'd0);
        tick;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset;
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_vec", 32'(irq_vec), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);

        // ---------------- single source, basic latency ----------------
        src_pulse = 4'b0100;
        tick;
        src_pulse = '0;
        check("t1_pending_set", 32'(pending), 32'h4);
        check("t1_irq_not_yet", 32'(irq), 32'd0);
        tick;
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_vec", 32'(irq_vec), 32'd2);
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        check("t1_pending_clr", 32'(pending), 32'd0);
        check("t1_irq_drop", 32'(irq), 32'd0);
        tick;
        check("t1_gap_low", 32'(irq), 32'd0);
        tick;
        check("t1_idle_low", 32'(irq), 32'd0);

        // ---------------- round-robin fairness ----------------
        do_reset;
        src_pulse = 4'hF;
        tick;
        src_pulse = '0;
        check("t2_pending_all", 32'(pending), 32'hF);
        tick;
        serve(2'd0, "rr0");
        serve(2'd1, "rr1");
        check("t2_pending_23", 32'(pending), 32'hC);
        src_pulse = 4'b1001;
        tick;
        src_pulse = '0;
        check("t2_repulse", 32'(pending), 32'hD);
        check("t2_vec_held", 32'(irq_vec), 32'd2);
        serve(2'd2, "rr2");
        serve(2'd3, "rr3");
        serve(2'd0, "rr0b");
        check("t2_done_irq", 32'(irq), 32'd0);
        check("t2_done_pend", 32'(pending), 32'd0);

        // ---------------- pulse and ack on the same source ----------------
        do_reset;
        src_pulse = 4'b0010;
        tick;
        src_pulse = '0;
        tick;
        check("t3_irq", 32'(irq), 32'd1);
        check("t3_vec", 32'(irq_vec), 32'd1);
        src_pulse = 4'b0010;
        irq_ack   = 1'b1;
        tick;
        src_pulse = '0;
        irq_ack   = 1'b0;
        check("t3_keep_flag", 32'(pending), 32'h2);
        check("t3_gap", 32'(irq), 32'd0);
        tick;
        check("t3_idle", 32'(irq), 32'd0);
        tick;
        check("t3_irq_again", 32'(irq), 32'd1);
        check("t3_vec_again", 32'(irq_vec), 32'd1);
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        check("t3_cleared", 32'(pending), 32'd0);

        // ---------------- enable drop, ignored ack, clr_all ----------------
        do_reset;
        src_pulse = 4'b0100;
        tick;
        src_pulse = '0;
        tick;
        check("t4_irq", 32'(irq), 32'd1);
        src_en = 4'b1011;
        tick;
        check("t4_withdraw", 32'(irq), 32'd0);
        check("t4_still_pend", 32'(pending), 32'h4);
        tick;
        check("t4_not_presented", 32'(irq), 32'd0);
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        check("t4_idle_ack_ignored", 32'(pending), 32'h4);
        check("t4_idle_irq", 32'(irq), 32'd0);
        src_en = 4'hF;
        tick;
        check("t4_reenable_irq", 32'(irq), 32'd1);
        check("t4_reenable_vec", 32'(irq_vec), 32'd2);
        clr_all = 1'b1;
        tick;
        clr_all = 1'b0;
        check("t4_clr_pend", 32'(pending), 32'd0);
        check("t4_clr_irq", 32'(irq), 32'd0);
        tick;
        check("t4_clr_stays", 32'(irq), 32'd0);

        // ---------------- reset mid-presentation ----------------
        do_reset;
        src_pulse = 4'b0100;
        tick;
        src_pulse = '0;
        tick;
        check("t5_irq", 32'(irq), 32'd1);
        R         = 1'b1;
        src_pulse = 4'hF;
        tick;
        R         = 1'b0;
        src_pulse = '0;
        check("t5_pend", 32'(pending), 32'd0);
        check("t5_irq_low", 32'(irq), 32'd0);
        check("t5_vec", 32'(irq_vec), 32'd0);
        check("t5_terr", 32'(timeout_err), 32'd0);
        tick;
        check("t5_quiet", 32'(irq), 32'd0);
        src_pulse = 4'hF;
        tick;
        src_pulse = '0;
        tick;
        check("t5_first_irq", 32'(irq), 32'd1);
        check("t5_first_vec", 32'(irq_vec), 32'd0);

`ifdef IRQ_TIMEOUT_EN
        // ---------------- timeout ----------------
        do_reset;
        src_pulse = 4'b0011;
        tick;
        src_pulse = '0;
        tick;
        repeat (7) tick;
        check("t6_irq_cycle8", 32'(irq), 32'd1);
        check("t6_terr_pre", 32'(timeout_err), 32'd0);
        tick;
        check("t6_to_irq", 32'(irq), 32'd0);
        check("t6_to_terr", 32'(timeout_err), 32'd1);
        check("t6_to_pend", 32'(pending), 32'h3);
        tick;
        check("t6_idle", 32'(irq), 32'd0);
        tick;
        check("t6_next_irq", 32'(irq), 32'd1);
        check("t6_next_vec", 32'(irq_vec), 32'd1);
        check("t6_terr_sticky", 32'(timeout_err), 32'd1);

        do_reset;
        check("t6_terr_rst", 32'(timeout_err), 32'd0);
        src_pulse = 4'b0011;
        tick;
        src_pulse = '0;
        tick;
        repeat (7) tick;
        check("t6b_irq", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        check("t6b_ack_irq", 32'(irq), 32'd0);
        check("t6b_ack_terr", 32'(timeout_err), 32'd0);
        check("t6b_ack_pend", 32'(pending), 32'h2);
        tick;
        tick;
        check("t6b_next_irq", 32'(irq), 32'd1);
        check("t6b_next_vec", 32'(irq_vec), 32'd1);
        check("t6b_terr_clear", 32'(timeout_err), 32'd0);
`else
        // ---------------- no timeout: presentation holds ----------------
        do_reset;
        src_pulse = 4'b0001;
        tick;
        src_pulse = '0;
        tick;
        repeat (20) tick;
        check("t6_hold_irq", 32'(irq), 32'd1);
        check("t6_hold_vec", 32'(irq_vec), 32'd0);
        check("t6_no_terr", 32'(timeout_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
